// File: rtl/can_bit_sync.sv
// can_bit_sync: CAN receive front end that synchronises can_rx, integrates bus idle,
// hard-syncs on SOF, generates the bit-time sample point and destuffs the bitstream.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   can_rx      in   raw CAN receive line (1 = recessive)
//   destuff_en  in   apply stuff rule to samples (sampled at the sample point only)
//   sof_detect  out  1-cycle pulse on SOF hard sync
//   bit_valid   out  1-cycle pulse: bit_value holds a destuffed data bit
//   bit_value   out  last sampled bit (held between samples)
//   stuff_err   out  1-cycle pulse: 6th equal sample while destuffing
//   frame_end   out  1-cycle pulse: IDLE_BITS recessive samples seen in a frame
//   bus_idle    out  level: bus idle, SOF armed
//
// Optional feature: define RESYNC_EN to enable soft resynchronisation on
// recessive-to-dominant edges inside a frame (limited by SJW, once per bit).
module can_bit_sync #(
    parameter int CLK_FREQ_MHZ  = 100,
    parameter int BIT_RATE_KBPS = 1000,
    parameter int SAMPLE_PCT    = 75,
    parameter int IDLE_BITS     = 11,
    parameter int SYNC_STAGES   = 2,
    parameter int SJW           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic can_rx,
    input  logic destuff_en,
    output logic sof_detect,
    output logic bit_valid,
    output logic bit_value,
    output logic stuff_err,
    output logic frame_end,
    output logic bus_idle
);
    localparam int BIT_TICKS   = CLK_FREQ_MHZ * 1000 / BIT_RATE_KBPS;
    localparam int SAMPLE_TICK = BIT_TICKS * SAMPLE_PCT / 100;
    // time-quantum counter is sized to also hold the early-resync sum e+SJW+1
    localparam int TW = $clog2(BIT_TICKS + SJW + 1);
    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [1:0] {INTEG, IDLE, RX} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_s_d, fall, sample, idle_hit;
    logic [TW-1:0]          tq_cnt, tq_nxt;
    logic [IW-1:0]          idle_cnt, idle_nxt;
    logic [2:0]             same_cnt, same_nxt;
    logic                   last_bit, last_nxt;
    logic                   sof_nxt, valid_nxt, value_nxt, err_nxt, end_nxt, idle_lvl_nxt;
`ifdef RESYNC_EN
    logic                   resynced, resynced_nxt;
    logic [TW-1:0]          late_tq, early_sum, early_tq;
`endif

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = rx_s_d & ~rx_s;
    assign sample   = tq_cnt == TW'(SAMPLE_TICK - 1);
    assign idle_hit = sample && rx_s && idle_cnt == IW'(IDLE_BITS - 1);

`ifdef RESYNC_EN
    // late edge: pull the phase back by up to SJW; early edge: push it forward,
    // where an edge closer than SJW to the bit end lands on tick 1 of the next bit
    assign late_tq   = (tq_cnt < TW'(SJW)) ? TW'(1) : tq_cnt - TW'(SJW - 1);
    assign early_sum = (tq_cnt > TW'(BIT_TICKS - SJW)) ? TW'(BIT_TICKS + 1) : tq_cnt + TW'(SJW + 1);
    assign early_tq  = (early_sum >= TW'(BIT_TICKS)) ? early_sum - TW'(BIT_TICKS) : early_sum;
`endif

    always_comb begin
        state_nxt    = state;
        tq_nxt       = (tq_cnt == TW'(BIT_TICKS - 1)) ? '0 : tq_cnt + TW'(1);
        idle_nxt     = idle_cnt;
        same_nxt     = same_cnt;
        last_nxt     = last_bit;
        value_nxt    = bit_value;
        idle_lvl_nxt = bus_idle;
        sof_nxt      = 1'b0;
        valid_nxt    = 1'b0;
        err_nxt      = 1'b0;
        end_nxt      = 1'b0;
`ifdef RESYNC_EN
        resynced_nxt = (tq_cnt == TW'(BIT_TICKS - 1)) ? 1'b0 : resynced;
`endif
        if (sample && state != IDLE)
            idle_nxt = (!rx_s || idle_hit) ? '0 : idle_cnt + IW'(1);
        case (state)
            INTEG: begin
                if (idle_hit) begin
                    state_nxt    = IDLE;
                    idle_lvl_nxt = 1'b1;
                end
            end
            IDLE: begin
                if (fall) begin
                    // the edge cycle itself is tick 0 of the SOF bit
                    tq_nxt       = TW'(1);
                    sof_nxt      = 1'b1;
                    idle_lvl_nxt = 1'b0;
                    same_nxt     = 3'd0;
                    state_nxt    = RX;
`ifdef RESYNC_EN
                    resynced_nxt = 1'b0;
`endif
                end
            end
            RX: begin
                if (sample) begin
                    value_nxt = rx_s;
                    if (destuff_en && same_cnt == 3'd5) begin
                        if (rx_s != last_bit) begin
                            same_nxt = 3'd1;
                            last_nxt = rx_s;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        valid_nxt = 1'b1;
                        same_nxt  = (rx_s != last_bit) ? 3'd1 : (same_cnt == 3'd5) ? 3'd5 : same_cnt + 3'd1;
                        last_nxt  = rx_s;
                    end
                    if (idle_hit) begin
                        end_nxt      = 1'b1;
                        idle_lvl_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
`ifdef RESYNC_EN
                else if (fall && !resynced && tq_cnt != '0) begin
                    tq_nxt       = (tq_cnt < TW'(SAMPLE_TICK - 1)) ? late_tq : early_tq;
                    // an early jump that wraps has already started the next bit
                    resynced_nxt = (tq_cnt < TW'(SAMPLE_TICK - 1)) || (early_tq > tq_cnt);
                end
`endif
            end
            default: state_nxt = INTEG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rx_s_d     <= 1'b1;
            state      <= INTEG;
            tq_cnt     <= '0;
            idle_cnt   <= '0;
            same_cnt   <= 3'd0;
            last_bit   <= 1'b0;
            sof_detect <= 1'b0;
            bit_valid  <= 1'b0;
            bit_value  <= 1'b0;
            stuff_err  <= 1'b0;
            frame_end  <= 1'b0;
            bus_idle   <= 1'b0;
`ifdef RESYNC_EN
            resynced   <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], can_rx};
            rx_s_d     <= rx_s;
            state      <= state_nxt;
            tq_cnt     <= tq_nxt;
            idle_cnt   <= idle_nxt;
            same_cnt   <= same_nxt;
            last_bit   <= last_nxt;
            sof_detect <= sof_nxt;
            bit_valid  <= valid_nxt;
            bit_value  <= value_nxt;
            stuff_err  <= err_nxt;
            frame_end  <= end_nxt;
            bus_idle   <= idle_lvl_nxt;
`ifdef RESYNC_EN
            resynced   <= resynced_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_can_bit_sync.sv
// tb_can_bit_sync: directed self-checking bench for can_bit_sync at 100 MHz / 1 Mbit/s.
module tb_can_bit_sync;
    logic clk = 1'b0, rst = 1'b1, can_rx = 1'b1, destuff_en = 1'b1;
    logic sof_detect, bit_valid, bit_value, stuff_err, frame_end, bus_idle;
    int ncmp = 0, nfail = 0, cyc = 0, base = 0;
    int sof_n = 0, valid_n = 0, err_n = 0, end_n = 0;
`ifdef RESYNC_EN
    localparam int SLIP = 4;
`else
    localparam int SLIP = 0;
`endif

    can_bit_sync dut (
        .clk(clk), .rst(rst), .can_rx(can_rx), .destuff_en(destuff_en),
        .sof_detect(sof_detect), .bit_valid(bit_valid), .bit_value(bit_value),
        .stuff_err(stuff_err), .frame_end(frame_end), .bus_idle(bus_idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sof_detect === 1'b1) sof_n++;
        if (bit_valid === 1'b1) valid_n++;
        if (stuff_err === 1'b1) err_n++;
        if (frame_end === 1'b1) end_n++;
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_cyc(input int t);
        adv(t - cyc);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SOF bit starting now; checks pulse timing and the SOF bit delivery
    task automatic send_sof();
        can_rx = 1'b0;
        adv(2);
        chk("sof_early", {7'b0, sof_detect}, 8'h00);
        adv(1);
        chk("sof_pulse", {6'b0, sof_detect, bus_idle}, 8'h02);
        adv(1);
        chk("sof_drop", {7'b0, sof_detect}, 8'h00);
        adv(73);
        chk("sof_bit", {3'b0, bus_idle, bit_valid, stuff_err, frame_end, bit_value}, 8'h08);
        adv(23);
    endtask

    // one 100-clk bit; exp = {bus_idle, bit_valid, stuff_err, frame_end, bit_value} at the sample
    task automatic send_bit(input string tag, input logic b, input logic de, input logic [4:0] exp);
        can_rx = b;
        destuff_en = de;
        adv(77);
        chk(tag, {3'b0, bus_idle, bit_valid, stuff_err, frame_end, bit_value}, {3'b0, exp});
        adv(1);
        chk({tag, "_after"}, {4'b0, sof_detect, bit_valid, stuff_err, frame_end}, 8'h00);
        adv(22);
    endtask

    initial begin
        adv(3);
        chk("reset", {2'b0, sof_detect, bit_valid, bit_value, stuff_err, frame_end, bus_idle}, 8'h00);
        rst = 1'b0;
        cyc = 0;
        // integration with a dominant bit at the 5th sample: count restarts
        goto_cyc(420);
        can_rx = 1'b0;
        goto_cyc(520);
        can_rx = 1'b1;
        goto_cyc(1100);
        chk("integ_restart", {7'b0, bus_idle}, 8'h00);
        goto_cyc(1574);
        chk("idle_before", {7'b0, bus_idle}, 8'h00);
        goto_cyc(1575);
        chk("idle_rise", {7'b0, bus_idle}, 8'h01);
        chk("integ_pulses", 8'(sof_n + valid_n + end_n + err_n), 8'h00);
        // data frame with a stuff 1 and a stuff 0, EOF received with destuffing off
        send_sof();
        for (int i = 0; i < 4; i++) send_bit("a_zero", 1'b0, 1'b1, 5'b01000);
        send_bit("a_stuff1", 1'b1, 1'b1, 5'b00001);
        send_bit("a_d1", 1'b1, 1'b1, 5'b01001);
        send_bit("a_d0", 1'b0, 1'b1, 5'b01000);
        for (int i = 0; i < 5; i++) send_bit("a_one", 1'b1, 1'b1, 5'b01001);
        send_bit("a_stuff0", 1'b0, 1'b1, 5'b00000);
        for (int i = 0; i < 10; i++) send_bit("a_eof", 1'b1, 1'b0, 5'b01001);
        send_bit("a_end", 1'b1, 1'b0, 5'b11011);
        // error frame: six dominant samples with destuffing on
        send_sof();
        for (int i = 0; i < 4; i++) send_bit("e_zero", 1'b0, 1'b1, 5'b01000);
        send_bit("e_err", 1'b0, 1'b1, 5'b00100);
        for (int i = 0; i < 10; i++) send_bit("e_rec", 1'b1, 1'b0, 5'b01001);
        send_bit("e_end", 1'b1, 1'b0, 5'b11011);
        // falling edge 10 clk late inside a frame
        destuff_en = 1'b1;
        send_sof();
        send_bit("r_one", 1'b1, 1'b1, 5'b01001);
        base = cyc;
        adv(10);
        can_rx = 1'b0;
        goto_cyc(base + 76 + SLIP);
        chk("resync_pre", {7'b0, bit_valid}, 8'h00);
        adv(1);
        chk("resync_bit", {3'b0, bus_idle, bit_valid, stuff_err, frame_end, bit_value}, 8'h08);
        goto_cyc(base + 100);
        can_rx = 1'b1;
        goto_cyc(base + 189);
        chk("pre_rst", {6'b0, bus_idle, bit_value}, 8'h01);
        // reset mid-frame; a dominant bit right after must not be taken as SOF
        rst = 1'b1;
        adv(1);
        chk("mid_rst", {2'b0, sof_detect, bit_valid, bit_value, stuff_err, frame_end, bus_idle}, 8'h00);
        rst = 1'b0;
        base = cyc;
        goto_cyc(base + 50);
        can_rx = 1'b0;
        goto_cyc(base + 150);
        can_rx = 1'b1;
        goto_cyc(base + 1174);
        chk("rst_idle_before", {7'b0, bus_idle}, 8'h00);
        goto_cyc(base + 1175);
        chk("rst_idle_rise", {7'b0, bus_idle}, 8'h01);
        adv(5);
        chk("sof_count", 8'(sof_n), 8'd3);
        chk("end_count", 8'(end_n), 8'd2);
        chk("err_count", 8'(err_n), 8'd1);
        chk("valid_count", 8'(valid_n), 8'd43);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
